// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch redirect,
// data-bus wait with timeout, and stall/redirect performance counters.
module pipe_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_jump_flag_i,
   input  logic [31:0]      ex_jump_addr_i,
   input  logic             ex_mem_r_ena_i,
   input  logic [4:0]       ex_reg_w_addr_i,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_rs1_use_i,
   input  logic             id_rs2_use_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             stall_pc_o,
   output logic             stall_if_id_o,
   output logic             stall_id_ex_o,
   output logic             stall_ex_mem_o,
   output logic             flush_if_id_o,
   output logic             flush_id_ex_o,
   output logic             pc_load_o,
   output logic [31:0]      pc_load_addr_o,
   output logic [1:0]       state_o,
   output logic             err_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } state_t;

   localparam int            WW  = $clog2(MEM_TIMEOUT + 2);
   localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

   state_t           state;
   state_t           state_nx;
   logic [WW-1:0]    wait_cnt;
   logic [WW-1:0]    wait_nx;
   logic [WW-1:0]    wait_inc;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             err;
   logic             load_use;
   logic             rs1_hit;
   logic             rs2_hit;
   logic             mem_busy;
   logic             stall_fe;
   logic             stall_be;
   logic             flush_fd;
   logic             flush_de;
   logic             load;

   assign rs1_hit  = id_rs1_use_i & (id_rs1_addr_i == ex_reg_w_addr_i);
   assign rs2_hit  = id_rs2_use_i & (id_rs2_addr_i == ex_reg_w_addr_i);
   assign load_use = ex_mem_r_ena_i & (ex_reg_w_addr_i != 5'd0)
                   & (rs1_hit | rs2_hit);
   assign mem_busy = mem_req_i & ~mem_ready_i;
   assign wait_inc = wait_cnt + WW'(1);

   always_comb begin
      state_nx = state;
      wait_nx  = wait_cnt;
      stall_fe = 1'b0;
      stall_be = 1'b0;
      flush_fd = 1'b0;
      flush_de = 1'b0;
      load     = 1'b0;
      unique case (state)
         RUN: begin
            if (mem_busy) begin
               stall_fe = 1'b1;
               stall_be = 1'b1;
               wait_nx  = '0;
               state_nx = MEM_WAIT;
            end else if (ex_jump_flag_i) begin
               load     = 1'b1;
               flush_fd = 1'b1;
               flush_de = 1'b1;
            end else if (load_use) begin
               stall_fe = 1'b1;
               flush_de = 1'b1;
               state_nx = LU_STALL;
            end
         end
         LU_STALL: begin
            state_nx = RUN;
            if (ex_jump_flag_i) begin
               load     = 1'b1;
               flush_fd = 1'b1;
               flush_de = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready_i) begin
               state_nx = RUN;
            end else begin
               stall_fe = 1'b1;
               stall_be = 1'b1;
               wait_nx  = wait_inc;
               if (wait_inc == TMO) state_nx = ERR;
            end
         end
         ERR: begin
            stall_fe = 1'b1;
            stall_be = 1'b1;
         end
         default: state_nx = RUN;
      endcase
      // reset squashes the pipe with bubbles rather than holding it
      if (rst) begin
         stall_fe = 1'b0;
         stall_be = 1'b0;
         flush_fd = 1'b1;
         flush_de = 1'b1;
         load     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         err       <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         if (stall_fe && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (load && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
         if (state_nx == ERR) err <= 1'b1;
      end
   end

   assign stall_pc_o     = stall_fe;
   assign stall_if_id_o  = stall_fe;
   assign stall_id_ex_o  = stall_be;
   assign stall_ex_mem_o = stall_be;
   assign flush_if_id_o  = flush_fd;
   assign flush_id_ex_o  = flush_de;
   assign pc_load_o      = load;
   assign pc_load_addr_o = load ? ex_jump_addr_i : 32'd0;
   assign state_o        = state;
   assign err_timeout_o  = err;
   assign stall_cnt_o    = stall_cnt;
   assign flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        jmp;
   logic [31:0] jaddr;
   logic        ld;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        use1;
   logic        use2;
   logic        req;
   logic        rdy;
   logic        st_pc;
   logic        st_fd;
   logic        st_de;
   logic        st_em;
   logic        fl_fd;
   logic        fl_de;
   logic        pcl;
   logic [31:0] pcl_addr;
   logic [1:0]  state;
   logic        err;
   logic [15:0] scnt;
   logic [15:0] fcnt;

   int vec = 0;
   int bad = 0;

   pipe_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .ex_jump_flag_i  (jmp),
      .ex_jump_addr_i  (jaddr),
      .ex_mem_r_ena_i  (ld),
      .ex_reg_w_addr_i (rd),
      .id_rs1_addr_i   (rs1),
      .id_rs2_addr_i   (rs2),
      .id_rs1_use_i    (use1),
      .id_rs2_use_i    (use2),
      .mem_req_i       (req),
      .mem_ready_i     (rdy),
      .stall_pc_o      (st_pc),
      .stall_if_id_o   (st_fd),
      .stall_id_ex_o   (st_de),
      .stall_ex_mem_o  (st_em),
      .flush_if_id_o   (fl_fd),
      .flush_id_ex_o   (fl_de),
      .pc_load_o       (pcl),
      .pc_load_addr_o  (pcl_addr),
      .state_o         (state),
      .err_timeout_o   (err),
      .stall_cnt_o     (scnt),
      .flush_cnt_o     (fcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, pc_load}
   function automatic logic [6:0] outs();
      return {st_pc, st_fd, st_de, st_em, fl_fd, fl_de, pcl};
   endfunction

   localparam logic [6:0] O_NONE = 7'b0000000;
   localparam logic [6:0] O_ALL  = 7'b1111000;
   localparam logic [6:0] O_LU   = 7'b1100010;
   localparam logic [6:0] O_JMP  = 7'b0000111;
   localparam logic [6:0] O_RST  = 7'b0000110;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      jmp = 0; jaddr = 32'hDEAD_BEEF; ld = 0; rd = 0; rs1 = 0; rs2 = 0;
      use1 = 0; use2 = 0; req = 0; rdy = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      jmp = 1; req = 1; ld = 1; rd = 3; rs1 = 3; use1 = 1;
      tick();
      @(negedge clk);
      vec++;
      if (outs() !== O_RST || pcl_addr !== 32'd0) begin
         bad++;
         $display("FAIL rst_outs: got %b/%h want %b/0", outs(), pcl_addr, O_RST);
      end
      tick();
      rst = 0;
      idle();
      @(negedge clk);
      vec++;
      if ({state, err, scnt, fcnt} !== 35'd0) begin
         bad++;
         $display("FAIL rst_state: got st=%0d err=%b s=%0d f=%0d want 0",
                  state, err, scnt, fcnt);
      end
      vec++;
      if (outs() !== O_NONE || pcl_addr !== 32'd0) begin
         bad++;
         $display("FAIL idle_outs: got %b/%h want 0/0", outs(), pcl_addr);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      ld = 1; rd = 5; rs1 = 5; use1 = 1; rs2 = 9; use2 = 1;
      @(negedge clk);
      vec++;
      if (outs() !== O_LU || state !== 2'd0) begin
         bad++;
         $display("FAIL lu_cycle: got %b st=%0d want %b st=0", outs(), state, O_LU);
      end
      tick();
      @(negedge clk);
      vec++;
      if (outs() !== O_NONE || state !== 2'd1) begin
         bad++;
         $display("FAIL lu_hold: got %b st=%0d want 0 st=1", outs(), state);
      end
      tick();
      idle();
      @(negedge clk);
      vec++;
      if (state !== 2'd0 || scnt !== 16'd1) begin
         bad++;
         $display("FAIL lu_after: got st=%0d s=%0d want st=0 s=1", state, scnt);
      end
      tick();
      ld = 1; rd = 7; rs2 = 7; use2 = 1; rs1 = 7; use1 = 0;
      @(negedge clk);
      vec++;
      if (outs() !== O_LU) begin
         bad++;
         $display("FAIL lu_rs2: got %b want %b", outs(), O_LU);
      end
      tick();
      idle();
      tick();
      ld = 1; rd = 7; rs1 = 7; rs2 = 7; use1 = 0; use2 = 0;
      @(negedge clk);
      vec++;
      if (outs() !== O_NONE) begin
         bad++;
         $display("FAIL lu_nouse: got %b want 0", outs());
      end
      tick();
   endtask

   task automatic test_rd_x0();
      do_reset();
      ld = 1; rd = 0; rs1 = 0; rs2 = 0; use1 = 1; use2 = 1;
      @(negedge clk);
      vec++;
      if (outs() !== O_NONE || state !== 2'd0) begin
         bad++;
         $display("FAIL x0_cycle: got %b st=%0d want 0 st=0", outs(), state);
      end
      tick();
      @(negedge clk);
      vec++;
      if (state !== 2'd0 || scnt !== 16'd0) begin
         bad++;
         $display("FAIL x0_after: got st=%0d s=%0d want 0 0", state, scnt);
      end
      tick();
   endtask

   task automatic test_jump_vs_load_use();
      do_reset();
      ld = 1; rd = 5; rs1 = 5; use1 = 1;
      jmp = 1; jaddr = 32'h0000_0100;
      @(negedge clk);
      vec++;
      if (outs() !== O_JMP || pcl_addr !== 32'h100) begin
         bad++;
         $display("FAIL jmp_cycle: got %b/%h want %b/100", outs(), pcl_addr, O_JMP);
      end
      tick();
      idle();
      @(negedge clk);
      vec++;
      if (state !== 2'd0 || fcnt !== 16'd1 || scnt !== 16'd0) begin
         bad++;
         $display("FAIL jmp_after: got st=%0d f=%0d s=%0d want 0 1 0",
                  state, fcnt, scnt);
      end
      vec++;
      if (pcl_addr !== 32'd0) begin
         bad++;
         $display("FAIL addr_zero: got %h want 0", pcl_addr);
      end
      tick();
   endtask

   task automatic test_bus_wait();
      do_reset();
      req = 1; rdy = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec++;
         if (outs() !== O_ALL || state !== (i == 0 ? 2'd0 : 2'd2)) begin
            bad++;
            $display("FAIL wait_%0d: got %b st=%0d want %b", i, outs(), state, O_ALL);
         end
         tick();
         jmp = 1; jaddr = 32'h0000_2000;
      end
      rdy = 1;
      @(negedge clk);
      vec++;
      if (outs() !== O_NONE || state !== 2'd2) begin
         bad++;
         $display("FAIL wait_ready: got %b st=%0d want 0 st=2", outs(), state);
      end
      tick();
      req = 0; rdy = 0;
      @(negedge clk);
      vec++;
      if (outs() !== O_JMP || state !== 2'd0 || scnt !== 16'd3) begin
         bad++;
         $display("FAIL wait_after: got %b st=%0d s=%0d want %b 0 3",
                  outs(), state, scnt, O_JMP);
      end
      tick();
      idle();
      req = 1; rdy = 1;
      @(negedge clk);
      vec++;
      if (outs() !== O_NONE || state !== 2'd0) begin
         bad++;
         $display("FAIL req_ready: got %b st=%0d want 0 0", outs(), state);
      end
      tick();
   endtask

   task automatic test_timeout_edge();
      do_reset();
      req = 1; rdy = 0;
      repeat (15) tick();
      rdy = 1;
      @(negedge clk);
      vec++;
      if (outs() !== O_NONE || state !== 2'd2) begin
         bad++;
         $display("FAIL tmo_edge: got %b st=%0d want 0 st=2", outs(), state);
      end
      tick();
      idle();
      @(negedge clk);
      vec++;
      if (state !== 2'd0 || err !== 1'b0) begin
         bad++;
         $display("FAIL tmo_edge_after: got st=%0d err=%b want 0 0", state, err);
      end
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      req = 1; rdy = 0;
      tick();
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         vec++;
         if (state !== 2'd2 || err !== 1'b0 || outs() !== O_ALL) begin
            bad++;
            $display("FAIL tmo_wait_%0d: got st=%0d err=%b want st=2 err=0",
                     i, state, err);
         end
         tick();
      end
      rdy = 1; jmp = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec++;
         if (state !== 2'd3 || err !== 1'b1 || outs() !== O_ALL) begin
            bad++;
            $display("FAIL tmo_err_%0d: got st=%0d err=%b o=%b want 3 1 %b",
                     i, state, err, outs(), O_ALL);
         end
         tick();
      end
      vec++;
      if (scnt !== 16'd19) begin
         bad++;
         $display("FAIL tmo_scnt: got %0d want 19", scnt);
      end
      rst = 1;
      @(negedge clk);
      vec++;
      if (outs() !== O_RST) begin
         bad++;
         $display("FAIL tmo_rst_outs: got %b want %b", outs(), O_RST);
      end
      tick();
      rst = 0;
      idle();
      @(negedge clk);
      vec++;
      if ({state, err, scnt, fcnt} !== 35'd0 || outs() !== O_NONE) begin
         bad++;
         $display("FAIL tmo_rst: got st=%0d err=%b s=%0d f=%0d want 0",
                  state, err, scnt, fcnt);
      end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      req = 1; rdy = 0;
      repeat (16) tick();
      req = 0;
      repeat (65534 - 16) tick();
      @(negedge clk);
      vec++;
      if (scnt !== 16'hFFFE) begin
         bad++;
         $display("FAIL sat_pre: got %h want fffe", scnt);
      end
      repeat (5) tick();
      @(negedge clk);
      vec++;
      if (scnt !== 16'hFFFF) begin
         bad++;
         $display("FAIL sat: got %h want ffff", scnt);
      end
      tick();
   endtask

   task automatic test_random();
      int          mode;
      int          waited;
      int          m_stalls;
      int          m_flushes;
      bit          m_err;
      bit          lu;
      logic [6:0]  e;
      logic [31:0] ea;
      int          nmode;
      do_reset();
      mode = 0; waited = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(63) == 0);
         jmp   = ($urandom_range(3) == 0);
         jaddr = $urandom();
         ld    = $urandom_range(1);
         rd    = 5'($urandom_range(3));
         rs1   = 5'($urandom_range(3));
         rs2   = 5'($urandom_range(3));
         use1  = $urandom_range(1);
         use2  = $urandom_range(1);
         req   = (mode != 1) && ($urandom_range(3) == 0);
         rdy   = ($urandom_range(2) != 0);
         lu = ld && rd != 0 && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
         nmode = mode;
         e = O_NONE;
         if (rst) begin
            e = O_RST;
         end else if (mode == 0) begin
            if (req && !rdy) begin
               e = O_ALL; nmode = 2; waited = 0;
            end else if (jmp) begin
               e = O_JMP;
            end else if (lu) begin
               e = O_LU; nmode = 1;
            end
         end else if (mode == 1) begin
            e = jmp ? O_JMP : O_NONE;
            nmode = 0;
         end else if (mode == 2) begin
            if (rdy) begin
               nmode = 0;
            end else begin
               e = O_ALL;
               waited++;
               if (waited == 15) nmode = 3;
            end
         end else begin
            e = O_ALL;
         end
         ea = e[0] ? jaddr : 32'd0;
         @(negedge clk);
         vec++;
         if (outs() !== e || pcl_addr !== ea) begin
            bad++;
            $display("FAIL rnd_out_%0d: got %b/%h want %b/%h",
                     n, outs(), pcl_addr, e, ea);
         end
         vec++;
         if (state !== 2'(mode) || err !== m_err
             || scnt !== 16'(m_stalls) || fcnt !== 16'(m_flushes)) begin
            bad++;
            $display("FAIL rnd_reg_%0d: got st=%0d e=%b s=%0d f=%0d want %0d %b %0d %0d",
                     n, state, err, scnt, fcnt, mode, m_err, m_stalls, m_flushes);
         end
         if (rst) begin
            mode = 0; waited = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
         end else begin
            mode = nmode;
            if (e[6] && m_stalls < 65535) m_stalls++;
            if (e[0] && m_flushes < 65535) m_flushes++;
            if (nmode == 3) m_err = 1;
         end
         tick();
      end
      rst = 0;
      idle();
   endtask

   initial begin
      idle();
      rst = 1;
      #1;
      test_reset();
      test_load_use();
      test_rd_x0();
      test_jump_vs_load_use();
      test_bus_wait();
      test_timeout_edge();
      test_timeout();
      test_random();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15: the maximum number of MEM_WAIT cycles before error.
REQ-003 The block SHALL have parameter CNT_W, default 16: the width of the performance counters.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_jump_flag_i  in  1  EX resolved taken branch/jump
- ex_jump_addr_i  in  32  jump target
- ex_mem_r_ena_i  in  1  instruction in EX is a load
- ex_reg_w_addr_i  in  5  rd of the instruction in EX
- id_rs1_addr_i, id_rs2_addr_i  in  5 each  source registers in ID
- id_rs1_use_i, id_rs2_use_i  in  1 each  ID actually reads rs1/rs2
- mem_req_i  in  1  MEM stage has an active data-bus access
- mem_ready_i  in  1  data bus completes the access this cycle
- stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o  out  1 each  hold register
- flush_if_id_o, flush_id_ex_o  out  1 each  load bubble into register
- pc_load_o  out  1  PC takes pc_load_addr_o
- pc_load_addr_o  out  32  redirect target
- state_o  out  2  current FSM state
- err_timeout_o  out  1  bus timeout, sticky
- stall_cnt_o  out  CNT_W  count of stall cycles
- flush_cnt_o  out  CNT_W  count of redirects

Function
REQ-005 The FSM SHALL have states RUN=0, LU_STALL=1, MEM_WAIT=2, ERR=3; state_o SHALL equal the registered state.
REQ-006 Control outputs SHALL be combinational from state and inputs; state, counters and err_timeout_o SHALL be registered.
REQ-007 load_use SHALL be defined as ex_mem_r_ena_i & (ex_reg_w_addr_i != 0) & ((id_rs1_use_i & rs1 == rd) | (id_rs2_use_i & rs2 == rd)).
REQ-008 In RUN, the block SHALL apply the following priority, highest first:
- mem_req_i & !mem_ready_i: assert all four stalls, no flush, pc_load_o=0; next state MEM_WAIT.
- ex_jump_flag_i: pc_load_o=1, pc_load_addr_o=ex_jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1, no stalls; stay in RUN (jump overrides load_use).
- load_use: stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1; next state LU_STALL.
- otherwise: all outputs 0.
REQ-009 LU_STALL SHALL last exactly one cycle, with no stall or flush asserted and load_use ignored; next state RUN. If ex_jump_flag_i is high in this state, it SHALL be handled as in RUN.
REQ-010 In MEM_WAIT, while mem_ready_i=0, the block SHALL assert all four stalls, no flush, and pc_load_o=0; it SHALL ignore jump and load_use.
REQ-011 In MEM_WAIT, when mem_ready_i=1, the block SHALL deassert all stalls in that same cycle and go to RUN next cycle. A jump pending in EX is taken in the following RUN cycle.
REQ-012 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with mem_ready_i=0.
REQ-013 When the wait counter reaches MEM_TIMEOUT, the FSM SHALL go to ERR. A mem_ready_i=1 in that same cycle wins, and the FSM goes to RUN instead.
REQ-014 In ERR, the block SHALL assert all stalls and err_timeout_o=1, and remain in ERR until rst.
REQ-015 mem_req_i with mem_ready_i=1 in the same cycle in RUN SHALL cause no stall.
REQ-016 stall_cnt_o SHALL increment each cycle stall_pc_o=1, saturating at all-ones.
REQ-017 flush_cnt_o SHALL increment each cycle pc_load_o=1, saturating at all-ones.
REQ-018 pc_load_addr_o SHALL be 0 whenever pc_load_o=0.

Reset
REQ-019 When rst=1 at a clk edge, the block SHALL set state to RUN, the wait counter, stall_cnt_o and flush_cnt_o to 0, and err_timeout_o to 0.
REQ-020 While rst=1, the block SHALL drive flush_if_id_o=flush_id_ex_o=1, all stalls 0, pc_load_o=0, and pc_load_addr_o=0.
REQ-021 rst SHALL abort MEM_WAIT, LU_STALL or ERR on the next edge with no residual stall.

Verification
REQ-022 Load-use: EX load rd=5, ID rs1=5 use=1 -> one cycle with stall_pc/if_id=1 and flush_id_ex=1, state 1, then RUN; stall_cnt=1.
REQ-023 Rd=x0: EX load rd=0, ID rs1=0 -> no stall, state stays 0.
REQ-024 Jump vs load-use: jump_flag=1, addr=0x0000_0100, with load_use true -> pc_load=1, addr 0x100, both flushes, no stall; flush_cnt=1.
REQ-025 Bus wait: mem_req=1, ready low 3 cycles then high -> 3 cycles of all stalls (state 2), stalls drop in the ready cycle, RUN next; stall_cnt=3.
REQ-026 Timeout: mem_req=1, ready never -> ERR after 15 wait cycles, err_timeout=1 held; rst pulse -> state 0, err=0, counters 0.
REQ-027 Saturation: force 2^16+3 stall cycles -> stall_cnt_o=0xFFFF.
